// File: rtl/mem_arb_ctrl.sv
// Two-port memory arbiter: an instruction-fetch port (0, read-only) and a
// load-store port (1) share one single-cycle memory strobe. One transaction
// in flight at most, round-robin choice on contention, and a programmable
// access latency sampled at grant.
module mem_arb_ctrl #(
    parameter int CNT_MAX_WIDTH = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CNT_MAX_WIDTH-1:0]  i_lat_bound,
    input  logic                      i_req0_valid,
    output logic                      o_req0_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req0_addr,
    output logic                      o_rsp0_valid,
    input  logic                      i_rsp0_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp0_rdata,
    input  logic                      i_req1_valid,
    output logic                      o_req1_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req1_addr,
    input  logic                      i_req1_wen,
    input  logic [DATA_WIDTH-1:0]     i_req1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_req1_wmask,
    output logic                      o_rsp1_valid,
    input  logic                      i_rsp1_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp1_rdata,
    output logic                      o_mem_en,
    output logic                      o_mem_wen,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_wmask,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam logic [CNT_MAX_WIDTH-1:0] CNT_ONE = {{(CNT_MAX_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_MAX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_MAX_WIDTH-1:0]  bound_q, bound_d;
    logic                      rr_q, rr_d;        // 1: requester 1 wins a tie
    logic                      id_q, id_d;        // owner of the in-flight transaction
    logic                      wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [MASK_W-1:0]         wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      mem_en_q, mem_en_d;
    logic                      rsp_vld_q, rsp_vld_d;

    logic                      sel0_s, sel1_s;
    logic                      hs0_s, hs1_s;
    logic [CNT_MAX_WIDTH-1:0]  eff_bound_s;
    logic [CNT_MAX_WIDTH-1:0]  cnt_inc_s;
    logic                      rsp_ready_s;

    // Requester selection and combinational ready for the chosen port in IDLE.
    always_comb begin
        sel1_s       = i_req1_valid & (~i_req0_valid | rr_q);
        sel0_s       = i_req0_valid & ~sel1_s;
        o_req0_ready = (state_q == ST_IDLE) & sel0_s;
        o_req1_ready = (state_q == ST_IDLE) & sel1_s;
        hs0_s        = i_req0_valid & o_req0_ready;
        hs1_s        = i_req1_valid & o_req1_ready;
        eff_bound_s  = (i_lat_bound == {CNT_MAX_WIDTH{1'b0}}) ? CNT_ONE : i_lat_bound;
        cnt_inc_s    = cnt_q + CNT_ONE;
        rsp_ready_s  = id_q ? i_rsp1_ready : i_rsp0_ready;
    end

    // Next-state logic; the memory strobe is pre-computed one cycle ahead so it leaves a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bound_d   = bound_q;
        rr_d      = rr_q;
        id_d      = id_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        mem_en_d  = 1'b0;
        rsp_vld_d = rsp_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (hs0_s | hs1_s) begin
                    state_d  = ST_WAIT;
                    id_d     = hs1_s;
                    rr_d     = hs0_s;
                    wen_d    = hs1_s & i_req1_wen;
                    addr_d   = hs1_s ? i_req1_addr : i_req0_addr;
                    wdata_d  = hs1_s ? i_req1_wdata : {DATA_WIDTH{1'b0}};
                    wmask_d  = hs1_s ? i_req1_wmask : {MASK_W{1'b0}};
                    bound_d  = eff_bound_s;
                    cnt_d    = {CNT_MAX_WIDTH{1'b0}};
                    mem_en_d = (eff_bound_s == CNT_ONE);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_en_q) begin
                    rdata_d   = wen_q ? {DATA_WIDTH{1'b0}} : i_mem_rdata;
                    cnt_d     = {CNT_MAX_WIDTH{1'b0}};
                    rsp_vld_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d    = cnt_inc_s;
                    mem_en_d = (cnt_inc_s == (bound_q - CNT_ONE));
                end
            end
            ST_RESP: begin
                if (rsp_ready_s) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    rsp_vld_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {CNT_MAX_WIDTH{1'b0}};
                rsp_vld_d = 1'b0;
            end
        endcase
    end

    // State register; reset drops any in-flight transaction and favours requester 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_MAX_WIDTH{1'b0}};
            bound_q   <= CNT_ONE;
            rr_q      <= 1'b0;
            id_q      <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wmask_q   <= {MASK_W{1'b0}};
            rdata_q   <= {DATA_WIDTH{1'b0}};
            mem_en_q  <= 1'b0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bound_q   <= bound_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            mem_en_q  <= mem_en_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign o_mem_en     = mem_en_q;
    assign o_mem_wen    = mem_en_q & wen_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_wmask  = wmask_q;
    assign o_rsp0_valid = rsp_vld_q & ~id_q;
    assign o_rsp1_valid = rsp_vld_q & id_q;
    assign o_rsp0_rdata = rdata_q;
    assign o_rsp1_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: arbitration, latency timing, write path,
// response back-pressure, bound change in flight, maximum bound, mid-flight reset.
module tb_mem_arb_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  lat_bound;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_addr;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_addr;
    logic        req1_wen;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_wmask;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_rdata;
    logic        mem_en, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arb_ctrl #(.CNT_MAX_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lat_bound(lat_bound),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_addr(req0_addr),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_rdata(rsp0_rdata),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_addr(req1_addr),
        .i_req1_wen(req1_wen), .i_req1_wdata(req1_wdata), .i_req1_wmask(req1_wmask),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_rdata(rsp1_rdata),
        .o_mem_en(mem_en), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; lat_bound = 8'd1;
        req0_valid = 1'b0; req0_addr = 32'h0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_addr = 32'h0; req1_wen = 1'b0;
        req1_wdata = 32'h0; req1_wmask = 4'h0; rsp1_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Both valid from reset: requester 0 first
        req0_valid = 1'b1; req0_addr = 32'h0000_1000;
        req1_valid = 1'b1; req1_addr = 32'h0000_2000; req1_wen = 1'b0;
        mem_rdata = 32'hAAAA_0001; lat_bound = 8'd1;
        #1;
        chk("rr_first_r0", 64'(req0_ready), 64'd1);
        chk("rr_first_r1", 64'(req1_ready), 64'd0);
        tick(); req0_valid = 1'b0; #1;
        chk("rr_b1_mem_en", 64'(mem_en), 64'd1);
        chk("rr_b1_addr", 64'(mem_addr), 64'h1000);
        chk("rr_wait_r1", 64'(req1_ready), 64'd0);
        tick(); rsp0_ready = 1'b1; #1;
        chk("rr_rsp0_valid", 64'(rsp0_valid), 64'd1);
        chk("rr_rsp0_rdata", 64'(rsp0_rdata), 64'hAAAA_0001);
        tick(); rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h0000_1004; mem_rdata = 32'hBBBB_0002; #1;
        chk("rr_idle_rsp0", 64'(rsp0_valid), 64'd0);
        chk("rr_second_r1", 64'(req1_ready), 64'd1);
        chk("rr_second_r0", 64'(req0_ready), 64'd0);
        tick(); req1_valid = 1'b0; #1;
        chk("rr_r1_mem_en", 64'(mem_en), 64'd1);
        chk("rr_r1_addr", 64'(mem_addr), 64'h2000);
        chk("rr_r1_wen", 64'(mem_wen), 64'd0);
        chk("rr_r1_wait_r0", 64'(req0_ready), 64'd0);
        tick(); rsp1_ready = 1'b1; #1;
        chk("rr_rsp1_valid", 64'(rsp1_valid), 64'd1);
        chk("rr_rsp1_rdata", 64'(rsp1_rdata), 64'hBBBB_0002);
        chk("rr_rsp1_not0", 64'(rsp0_valid), 64'd0);
        tick(); rsp1_ready = 1'b0; req1_valid = 1'b1; #1;
        chk("rr_third_r0", 64'(req0_ready), 64'd1);
        chk("rr_third_r1", 64'(req1_ready), 64'd0);

        // Valids dropped before any edge: nothing happens
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        // Write from requester 1, bound 0 treated as 1
        req1_valid = 1'b1; req1_addr = 32'h0000_0040; req1_wen = 1'b1;
        req1_wdata = 32'hDEAD_BEEF; req1_wmask = 4'h3; lat_bound = 8'd0;
        mem_rdata = 32'h1111_1111; #1;
        chk("drop_idle_r1", 64'(req1_ready), 64'd1);
        chk("drop_no_mem_en", 64'(mem_en), 64'd0);
        tick(); req1_valid = 1'b0; #1;
        chk("wr_mem_en", 64'(mem_en), 64'd1);
        chk("wr_mem_wen", 64'(mem_wen), 64'd1);
        chk("wr_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("wr_wmask", 64'(mem_wmask), 64'h3);
        chk("wr_addr", 64'(mem_addr), 64'h40);
        tick(); rsp0_ready = 1'b1; #1;
        // Back-pressure on response 1, foreign ready ignored
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
            chk("bp_rsp1_rdata", 64'(rsp1_rdata), 64'd0);
            tick();
        end
        chk("bp_still_valid", 64'(rsp1_valid), 64'd1);
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        tick(); rsp1_ready = 1'b0; req1_wen = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h0000_3000; lat_bound = 8'd4;
        mem_rdata = 32'h5555_AAAA; #1;
        chk("bp_done_valid", 64'(rsp1_valid), 64'd0);
        chk("bp_idle_r0", 64'(req0_ready), 64'd1);

        // Bound changes from 4 to 1 while waiting: strobe still at T+4
        tick(); req0_valid = 1'b0; lat_bound = 8'd1; #1;
        chk("lb_t1", 64'(mem_en), 64'd0);
        tick(); chk("lb_t2", 64'(mem_en), 64'd0);
        tick(); chk("lb_t3", 64'(mem_en), 64'd0);
        tick();
        chk("lb_t4", 64'(mem_en), 64'd1);
        chk("lb_t4_addr", 64'(mem_addr), 64'h3000);
        tick();
        chk("lb_rsp0_valid", 64'(rsp0_valid), 64'd1);
        chk("lb_rsp0_rdata", 64'(rsp0_rdata), 64'h5555_AAAA);
        rsp0_ready = 1'b1;
        tick(); rsp0_ready = 1'b0; #1;
        chk("lb_done", 64'(rsp0_valid), 64'd0);

        // Maximum bound 255: strobe exactly at T+255
        req0_valid = 1'b1; req0_addr = 32'h0000_0FF0; lat_bound = 8'hFF;
        mem_rdata = 32'h0BAD_F00D; #1;
        chk("max_r0", 64'(req0_ready), 64'd1);
        tick(); req0_valid = 1'b0;
        for (int i = 1; i < 255; i++) begin
            chk("max_no_en", 64'(mem_en), 64'd0);
            tick();
        end
        chk("max_en", 64'(mem_en), 64'd1);
        tick();
        chk("max_rsp0_rdata", 64'({rsp0_valid, rsp0_rdata}), {31'd0, 1'b1, 32'h0BAD_F00D});
        rsp0_ready = 1'b1;
        tick(); rsp0_ready = 1'b0;

        // Reset during WAIT with bound 10
        req1_valid = 1'b1; req1_addr = 32'h0000_4000; req1_wen = 1'b0; lat_bound = 8'd10; #1;
        chk("rw_r1", 64'(req1_ready), 64'd1);
        tick(); req1_valid = 1'b0; #1;
        chk("rw_wait_en", 64'(mem_en), 64'd0);
        tick(); tick();
        rst_n = 1'b0; #1;
        chk("rw_rst_en", 64'({mem_en, mem_wen}), 64'd0);
        chk("rw_rst_addr", 64'(mem_addr), 64'd0);
        chk("rw_rst_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rw_rst_rdata", 64'({rsp0_rdata, rsp1_rdata}), 64'd0);
        chk("rw_rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rw_quiet", 64'({mem_en, rsp0_valid, rsp1_valid}), 64'd0);
        end
        req0_valid = 1'b1; req0_addr = 32'h0000_5000;
        req1_valid = 1'b1; req1_addr = 32'h0000_6000;
        lat_bound = 8'd2; mem_rdata = 32'h7777_8888; #1;
        chk("rw_new_r0", 64'(req0_ready), 64'd1);
        chk("rw_new_r1", 64'(req1_ready), 64'd0);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
        chk("rw_new_t1", 64'(mem_en), 64'd0);
        tick();
        chk("rw_new_t2", 64'(mem_en), 64'd1);
        chk("rw_new_addr", 64'(mem_addr), 64'h5000);
        tick();
        chk("rw_new_rsp", 64'({rsp0_valid, rsp0_rdata}), {31'd0, 1'b1, 32'h7777_8888});
        rsp0_ready = 1'b1;
        tick(); rsp0_ready = 1'b0; #1;
        chk("rw_new_done", 64'(rsp0_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter CNT_MAX_WIDTH, default 8, the width of the latency bound and the latency counter.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, the data width; the write mask is DATA_WIDTH/8 bits.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_lat_bound  input  CNT_MAX_WIDTH  access latency in cycles, sampled at grant.
REQ-007 i_req0_valid / o_req0_ready / i_req0_addr  in/out/in  1/1/ADDR_WIDTH  requester 0 (instruction fetch), read-only request channel.
REQ-008 o_rsp0_valid / i_rsp0_ready / o_rsp0_rdata  out/in/out  1/1/DATA_WIDTH  requester 0 response channel.
REQ-009 i_req1_valid / o_req1_ready / i_req1_addr / i_req1_wen / i_req1_wdata / i_req1_wmask  in/out/in/in/in/in  1/1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  requester 1 (load-store) request channel.
REQ-010 o_rsp1_valid / i_rsp1_ready / o_rsp1_rdata  out/in/out  1/1/DATA_WIDTH  requester 1 response channel.
REQ-011 o_mem_en / o_mem_wen / o_mem_addr / o_mem_wdata / o_mem_wmask  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  single-cycle memory access strobe and payload.
REQ-012 i_mem_rdata  input  DATA_WIDTH  combinational read data, valid in the cycle o_mem_en is high.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; one transaction in flight at most.
REQ-014 IDLE: o_reqN_ready SHALL be driven combinationally high only for the selected requester; no ready in WAIT/RESP.
REQ-015 Selection: only one valid -> that one; both valid -> the requester not granted last (round-robin pointer, updated on each handshake).
REQ-016 Handshake (valid & ready) SHALL register addr, wen, wdata, wmask, requester id and bound, and move to WAIT; requester 0 wen forced 0.
REQ-017 Effective bound = i_lat_bound, except 0 treated as 1; later i_lat_bound changes SHALL NOT affect the in-flight transaction.
REQ-018 WAIT: counter starts at 0 and increments each cycle; when counter == bound-1, assert o_mem_en (plus o_mem_wen for writes) for exactly one cycle, capture i_mem_rdata, clear counter, go to RESP.
REQ-019 Timing: handshake in cycle T -> o_mem_en in cycle T+bound -> o_rspN_valid from cycle T+bound+1.
REQ-020 o_mem_addr/wdata/wmask SHALL carry registered values whenever o_mem_en is high; writes return rdata = 0.
REQ-021 RESP: o_rspN_valid held high with stable rdata until i_rspN_ready; then go to IDLE; no new grant in the same cycle.
REQ-022 Valid dropped in IDLE before handshake SHALL leave no state change; ready on non-owned response channel is ignored.
REQ-023 Counter SHALL never exceed bound-1; bound = 2^CNT_MAX_WIDTH-1 SHALL work without overflow.

Reset
REQ-024 Reset, including mid-transaction, SHALL force IDLE, counter 0, pointer favouring requester 0, and all outputs 0 (ready values then from IDLE logic), dropping any in-flight transaction without a mem strobe or response.

Verification
REQ-025 req0 read at 0x8000_0000, bound=3, handshake at T -> o_mem_en at T+3, o_rsp0_valid at T+4 with the mem data.
REQ-026 Both valid from reset -> req0 granted first, req1 after req0 response completes; both valid again -> req1 granted (round-robin).
REQ-027 req1 write wdata=0xDEADBEEF, wmask=0x3, bound=0 -> o_mem_en and o_mem_wen at T+1 with that payload; rsp1 rdata = 0.
REQ-028 i_rsp1_ready held low 5 cycles -> o_rsp1_valid and rdata stable throughout; IDLE on the cycle after ready.
REQ-029 i_rst_n low during WAIT with bound=10 -> no o_mem_en; all outputs 0; a new request accepted normally after release.
REQ-030 i_lat_bound changed from 4 to 1 during WAIT -> mem strobe still at T+4.
